// File: rtl/i2c_addr_pointer.sv
// Registered I2C memory address pointer: stages the high address byte, commits both
// halves atomically on the low byte, then auto-increments (page-wrapped writes, linear reads).
module i2c_addr_pointer #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned PAGE_BITS  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            addr_byte_i,
    input  logic                  load_hi_i,
    input  logic                  load_lo_i,
    input  logic                  abort_i,
    input  logic                  incr_wr_i,
    input  logic                  incr_rd_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_valid_o,
    output logic                  page_wrap_o
);

    localparam int unsigned HiWidth = ADDR_WIDTH - 8;

    if (ADDR_WIDTH < 9 || ADDR_WIDTH > 16) begin : g_bad_addr_width
        $error("i2c_addr_pointer: ADDR_WIDTH must be within 9..16");
    end
    if (PAGE_BITS < 1 || PAGE_BITS > ADDR_WIDTH - 1) begin : g_bad_page_bits
        $error("i2c_addr_pointer: PAGE_BITS must be within 1..ADDR_WIDTH-1");
    end

    typedef enum logic [0:0] {
        StIdle,
        StPend
    } state_e;

    state_e                  state_q, state_d;
    logic [HiWidth-1:0]      hi_stage_q, hi_stage_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    addr_valid_q, addr_valid_d;
    logic                    page_wrap_q, page_wrap_d;

    logic [PAGE_BITS-1:0]    page_low;
    logic [PAGE_BITS-1:0]    page_low_inc;
    logic [ADDR_WIDTH-1:0]   addr_wr_inc;
    logic [ADDR_WIDTH-1:0]   addr_rd_inc;
    logic                    commit;
    logic                    drop_stage;

    assign page_low     = addr_q[PAGE_BITS-1:0];
    assign page_low_inc = page_low + PAGE_BITS'(1);
    assign addr_wr_inc  = {addr_q[ADDR_WIDTH-1:PAGE_BITS], page_low_inc};
    assign addr_rd_inc  = addr_q + ADDR_WIDTH'(1);

    assign commit     = (state_q == StPend) && load_lo_i;
    assign drop_stage = (state_q == StPend) && abort_i;

    always_comb begin
        state_d      = state_q;
        hi_stage_d   = hi_stage_q;
        addr_d       = addr_q;
        addr_valid_d = addr_valid_q;
        page_wrap_d  = 1'b0;

        if (commit) begin
            // The commit owns addr this cycle; any concurrent increment is dropped.
            addr_d       = {hi_stage_q, addr_byte_i};
            addr_valid_d = 1'b1;
            hi_stage_d   = '0;
            state_d      = StIdle;
        end else begin
            if (drop_stage) begin
                hi_stage_d = '0;
                state_d    = StIdle;
            end else if (load_hi_i) begin
                hi_stage_d = addr_byte_i[HiWidth-1:0];
                state_d    = StPend;
            end

            // The committed pointer keeps moving while a new high byte is staged.
            if (addr_valid_q) begin
                if (incr_wr_i) begin
                    addr_d      = addr_wr_inc;
                    page_wrap_d = &page_low;
                end else if (incr_rd_i) begin
                    addr_d = addr_rd_inc;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            hi_stage_q   <= '0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            page_wrap_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_stage_q   <= hi_stage_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            page_wrap_q  <= page_wrap_d;
        end
    end

    assign addr_o       = addr_q;
    assign addr_valid_o = addr_valid_q;
    assign page_wrap_o  = page_wrap_q;

endmodule

// File: tb/tb_i2c_addr_pointer.sv
// Directed bench for i2c_addr_pointer: 16-bit and 10-bit instances share one stimulus stream.
module tb_i2c_addr_pointer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr_byte;
    logic        load_hi, load_lo, abort, incr_wr, incr_rd;
    logic [15:0] a16;
    logic        v16, w16;
    logic [9:0]  a10;
    logic        v10, w10;

    int unsigned pass_cnt = 0;
    int unsigned total    = 0;

    always #5 clk = ~clk;

    i2c_addr_pointer #(.ADDR_WIDTH(16), .PAGE_BITS(6)) dut16 (
        .clk_i(clk), .rst_i(rst), .addr_byte_i(addr_byte),
        .load_hi_i(load_hi), .load_lo_i(load_lo), .abort_i(abort),
        .incr_wr_i(incr_wr), .incr_rd_i(incr_rd),
        .addr_o(a16), .addr_valid_o(v16), .page_wrap_o(w16)
    );

    i2c_addr_pointer #(.ADDR_WIDTH(10), .PAGE_BITS(6)) dut10 (
        .clk_i(clk), .rst_i(rst), .addr_byte_i(addr_byte),
        .load_hi_i(load_hi), .load_lo_i(load_lo), .abort_i(abort),
        .incr_wr_i(incr_wr), .incr_rd_i(incr_rd),
        .addr_o(a10), .addr_valid_o(v10), .page_wrap_o(w10)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        rst = 1'b0; load_hi = 1'b0; load_lo = 1'b0; abort = 1'b0;
        incr_wr = 1'b0; incr_rd = 1'b0; addr_byte = 8'h00;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load(input logic [7:0] hi, input logic [7:0] lo);
        load_hi = 1'b1; addr_byte = hi; tick();
        load_lo = 1'b1; addr_byte = lo; tick();
    endtask

    task automatic chk16(input string tag, input logic [15:0] a, input logic v, input logic w);
        chk({tag, ".addr"}, a16, a);
        chk({tag, ".valid"}, {15'd0, v16}, {15'd0, v});
        chk({tag, ".wrap"}, {15'd0, w16}, {15'd0, w});
    endtask

    initial begin
        idle();
        #1;
        // Reset then load
        rst = 1'b1; tick();
        rst = 1'b1; tick();
        chk16("reset", 16'h0000, 1'b0, 1'b0);
        load_hi = 1'b1; addr_byte = 8'h12; tick();
        chk16("load_hi_only", 16'h0000, 1'b0, 1'b0);
        load_lo = 1'b1; addr_byte = 8'h34; tick();
        chk16("load_commit", 16'h1234, 1'b1, 1'b0);

        // Page wrap on writes
        load(8'h12, 8'h3E);
        chk16("wr_start", 16'h123E, 1'b1, 1'b0);
        incr_wr = 1'b1; tick();
        chk16("wr_1", 16'h123F, 1'b1, 1'b0);
        incr_wr = 1'b1; tick();
        chk16("wr_2_wrap", 16'h1200, 1'b1, 1'b1);
        incr_wr = 1'b1; tick();
        chk16("wr_3", 16'h1201, 1'b1, 1'b0);

        // Read wrap, including the narrow instance
        load(8'hFF, 8'hFF);
        chk("rd10_commit", {6'd0, a10}, 16'h03FF);
        incr_rd = 1'b1; tick();
        chk("rd10_wrap", {6'd0, a10}, 16'h0000);
        chk16("rd16_wrap_ffff", 16'h0000, 1'b1, 1'b0);
        load(8'hFF, 8'hFE);
        incr_rd = 1'b1; tick();
        chk16("rd_1", 16'hFFFF, 1'b1, 1'b0);
        incr_rd = 1'b1; tick();
        chk16("rd_2", 16'h0000, 1'b1, 1'b0);
        incr_rd = 1'b1; tick();
        chk16("rd_3", 16'h0001, 1'b1, 1'b0);

        // Abort discards the staged byte; a following loadLo is ignored
        load(8'h12, 8'h34);
        load_hi = 1'b1; addr_byte = 8'h56; tick();
        abort = 1'b1; tick();
        load_lo = 1'b1; addr_byte = 8'h78; tick();
        chk16("abort", 16'h1234, 1'b1, 1'b0);
        load_lo = 1'b1; addr_byte = 8'h9A; tick();
        chk16("lo_in_idle", 16'h1234, 1'b1, 1'b0);

        // Simultaneous increments: the page path wins
        incr_wr = 1'b1; incr_rd = 1'b1; tick();
        chk16("wr_rd_both", 16'h1235, 1'b1, 1'b0);
        load(8'h12, 8'h3F);
        incr_wr = 1'b1; incr_rd = 1'b1; tick();
        chk16("wr_rd_both_wrap", 16'h1200, 1'b1, 1'b1);

        // Commit beats a concurrent read increment
        load_hi = 1'b1; addr_byte = 8'h56; tick();
        load_lo = 1'b1; addr_byte = 8'h78; incr_rd = 1'b1; tick();
        chk16("lo_plus_rd", 16'h5678, 1'b1, 1'b0);

        // Increments honoured while a high byte is pending
        load_hi = 1'b1; addr_byte = 8'h11; tick();
        incr_rd = 1'b1; tick();
        chk16("rd_in_pend", 16'h5679, 1'b1, 1'b0);
        load_lo = 1'b1; addr_byte = 8'h22; tick();
        chk16("commit_after_pend_rd", 16'h1122, 1'b1, 1'b0);

        // abort beats loadHi in PEND
        load_hi = 1'b1; addr_byte = 8'h12; tick();
        abort = 1'b1; load_hi = 1'b1; addr_byte = 8'h99; tick();
        load_lo = 1'b1; addr_byte = 8'h55; tick();
        chk16("abort_over_hi", 16'h1122, 1'b1, 1'b0);

        // Increments before any commit are ignored
        rst = 1'b1; tick();
        chk16("reset_2", 16'h0000, 1'b0, 1'b0);
        incr_rd = 1'b1; tick();
        chk16("rd_uncommitted", 16'h0000, 1'b0, 1'b0);
        incr_wr = 1'b1; tick();
        chk16("wr_uncommitted", 16'h0000, 1'b0, 1'b0);

        // Reset mid-load
        load_hi = 1'b1; addr_byte = 8'hAB; tick();
        rst = 1'b1; tick();
        chk16("rst_mid_load", 16'h0000, 1'b0, 1'b0);
        load_lo = 1'b1; addr_byte = 8'hCD; tick();
        chk16("lo_after_rst", 16'h0000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
